muldiv_unit: RTL

- Parametrised multi-cycle RV32M/RV64M multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- The EX stage holds the instruction and stalls F/D/E while the unit iterates.
- Adds modes the single-cycle ALU lacks: signed/unsigned high multiply, divide, remainder, an abort path for pipeline flush, and a fast path for special-case divides.
- Operands arrive already forwarded (after the EX forwarding muxes).

---
 rtl/muldiv_if.sv | 16 +
 rtl/muldiv_unit.sv | 108 ++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the EX stage and the multiply/divide unit
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] srca;
    logic [XLEN-1:0] srcb;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, op, srca, srcb, flush, input busy, done, result);
    modport slave  (input start, op, srca, srcb, flush, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M/RV64M multiply/divide unit with flush abort and special-case divide fast path
module muldiv_unit #(
    parameter  int XLEN = 32,
    localparam int CNTW = $clog2(XLEN + 1)
) (
    input logic     clk,
    input logic     reset,
    muldiv_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [CNTW-1:0]   r_cnt;
    logic [2:0]        r_op;
    logic              r_neg;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_result;
    logic [2*XLEN-1:0] r_prod;

    logic              w_div_in;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_neg_in;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_spec_res;
    logic              w_accept;
    logic              w_last;
    logic [XLEN:0]     w_msum;
    logic [XLEN:0]     w_dsh;
    logic [XLEN:0]     w_ddiff;
    logic [2*XLEN-1:0] w_next;
    logic [2*XLEN-1:0] w_mfin;
    logic [XLEN-1:0]   w_dval;
    logic [XLEN-1:0]   w_dfin;
    logic [XLEN-1:0]   w_final;

    // Operand sign handling: MUL/MULH sign both, MULHSU only rs1, DIV/REM both, U-variants none
    assign w_div_in   = bus.op[2];
    assign w_sa       = bus.srca[XLEN-1] & (w_div_in ? ~bus.op[0] : (bus.op != 3'b011));
    assign w_sb       = bus.srcb[XLEN-1] & (w_div_in ? ~bus.op[0] : ~bus.op[1]);
    assign w_mag_a    = w_sa ? -bus.srca : bus.srca;
    assign w_mag_b    = w_sb ? -bus.srcb : bus.srcb;
    // The remainder takes the dividend's sign; everything else takes the XOR of both signs
    assign w_neg_in   = (w_div_in & bus.op[1]) ? w_sa : (w_sa ^ w_sb);
    assign w_div0     = w_div_in & ~|bus.srcb;
    assign w_ovf      = w_div_in & ~bus.op[0] & (bus.srca == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.srcb);
    assign w_special  = w_div0 | w_ovf;
    assign w_spec_res = w_div0 ? (bus.op[1] ? bus.srca : '1) : (bus.op[1] ? '0 : bus.srca);
    assign w_accept   = bus.start & ~bus.flush & (r_state != S_BUSY);
    assign w_last     = r_cnt == CNTW'(XLEN - 1);

    // r_prod holds {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide
    assign w_msum  = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_b} : '0);
    assign w_dsh   = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
    assign w_ddiff = w_dsh - {1'b0, r_b};
    assign w_next  = r_op[2]
                   ? (w_ddiff[XLEN] ? {w_dsh[XLEN-1:0], r_prod[XLEN-2:0], 1'b0}
                                    : {w_ddiff[XLEN-1:0], r_prod[XLEN-2:0], 1'b1})
                   : {w_msum, r_prod[XLEN-1:1]};

    // Sign correction applied to the value produced by the final iteration
    assign w_mfin  = r_neg ? -w_next : w_next;
    assign w_dval  = r_op[1] ? w_next[2*XLEN-1:XLEN] : w_next[XLEN-1:0];
    assign w_dfin  = r_neg ? -w_dval : w_dval;
    assign w_final = r_op[2] ? w_dfin : ((r_op[1:0] == 2'b00) ? w_mfin[XLEN-1:0] : w_mfin[2*XLEN-1:XLEN]);

    assign bus.busy   = r_state == S_BUSY;
    assign bus.done   = r_state == S_DONE;
    assign bus.result = r_result;

    // Control FSM and datapath; flush outranks start, and result survives flush and leaving DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_b      <= '0;
            r_prod   <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op    <= bus.op;
            r_neg   <= w_neg_in;
            r_cnt   <= '0;
            r_b     <= w_div_in ? w_mag_b : w_mag_a;
            r_prod  <= {{XLEN{1'b0}}, w_div_in ? w_mag_a : w_mag_b};
            r_state <= w_special ? S_DONE : S_BUSY;
            if (w_special) r_result <= w_spec_res;
        end else if (bus.flush) begin
            r_state <= S_IDLE;
        end else if (r_state == S_BUSY) begin
            r_prod <= w_next;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
                r_state  <= S_DONE;
                r_result <= w_final;
            end
        end else if (r_state == S_DONE) begin
            r_state <= S_IDLE;
        end
    end
endmodule
